// File: rtl/shift_arbiter.sv
// Shares one 8-bit shift/rotate datapath between two requesters: round-robin grant (fixed priority with SHIFT_ARB_FIXED_PRIO_EN).
// Latency: accept at T, EXEC at T+1, registered result valid from T+2; 3-cycle issue interval.
// Backpressure: result held in DONE until o_ready; no request is accepted while busy.
module shift_arbiter (
    input  logic       clk,
    input  logic       nrst,
    input  logic       v0,
    input  logic       v1,
    output logic       rdy0,
    output logic       rdy1,
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    input  logic [3:0] n0,
    input  logic [3:0] n1,
    input  logic       ar0,
    input  logic       ar1,
    input  logic       lr0,
    input  logic       lr1,
    input  logic       rot0,
    input  logic       rot1,
    output logic [7:0] o,
    output logic       o_id,
    output logic       o_valid,
    input  logic       o_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state, state_nxt;
    logic       gnt1;
    logic       take;
    logic [7:0] op_i;
    logic [3:0] op_n;
    logic       op_ar, op_lr, op_rot, op_id;
    logic [3:0] samt, ramt;
    logic [7:0] res;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign gnt1 = v1 & ~v0;
`else
    // last served port; reset value 1 lets port 0 win the first tie
    logic last;
    assign gnt1 = v1 & (~v0 | ~last);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            last <= 1'b1;
        else if (take)
            last <= gnt1;
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                // gated by nrst so ready stays low while reset is held
                rdy0 = nrst & v0 & ~gnt1;
                rdy1 = nrst & gnt1;
                take = v0 | v1;
                if (take)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = DONE;
            DONE: begin
                o_valid = 1'b1;
                if (o_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_i   <= 8'h00;
            op_n   <= 4'h0;
            op_ar  <= 1'b0;
            op_lr  <= 1'b0;
            op_rot <= 1'b0;
            op_id  <= 1'b0;
        end else if (take) begin
            op_i   <= gnt1 ? i1   : i0;
            op_n   <= gnt1 ? n1   : n0;
            op_ar  <= gnt1 ? ar1  : ar0;
            op_lr  <= gnt1 ? lr1  : lr0;
            op_rot <= gnt1 ? rot1 : rot0;
            op_id  <= gnt1;
        end
    end

    // shifts saturate at 8, rotates wrap modulo 8
    always_comb begin
        samt = op_n[3] ? 4'd8 : op_n;
        ramt = {1'b0, op_n[2:0]};
        res  = 8'h00;
        if (op_rot)
            res = op_lr ? ((op_i << ramt) | (op_i >> (4'd8 - ramt)))
                        : ((op_i >> ramt) | (op_i << (4'd8 - ramt)));
        else if (op_lr)
            res = op_i << samt;
        else if (op_ar)
            res = $unsigned($signed(op_i) >>> samt);
        else
            res = op_i >> samt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o    <= 8'h00;
            o_id <= 1'b0;
        end else if (state == EXEC) begin
            o    <= res;
            o_id <= op_id;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, single op, tie fairness, backpressure, saturation/wrap, reset mid-op.
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       v0, v1, rdy0, rdy1;
    logic [7:0] i0, i1, o;
    logic [3:0] n0, n1;
    logic       ar0, ar1, lr0, lr1, rot0, rot1;
    logic       o_id, o_valid, o_ready;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter dut (
        .clk(clk), .nrst(nrst),
        .v0(v0), .v1(v1), .rdy0(rdy0), .rdy1(rdy1),
        .i0(i0), .i1(i1), .n0(n0), .n1(n1),
        .ar0(ar0), .ar1(ar1), .lr0(lr0), .lr1(lr1),
        .rot0(rot0), .rot1(rot1),
        .o(o), .o_id(o_id), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nrst = 1'b0; o_ready = 1'b1;
        v0 = 1'b1; i0 = 8'h96; n0 = 4'd3; ar0 = 1'b1; lr0 = 1'b0; rot0 = 1'b0;
        v1 = 1'b1; i1 = 8'h55; n1 = 4'd1; ar1 = 1'b0; lr1 = 1'b1; rot1 = 1'b0;

        // reset held with both ports requesting
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_rdy0",  32'(rdy0),    0);
            check("rst_rdy1",  32'(rdy1),    0);
            check("rst_o",     32'(o),       0);
            check("rst_o_id",  32'(o_id),    0);
            check("rst_valid", 32'(o_valid), 0);
        end

        // release: port 0 wins first tie; 0x96 asr 3 = 0xF2
        nrst = 1'b1;
        #1;
        check("rel_rdy0", 32'(rdy0), 1);
        check("rel_rdy1", 32'(rdy1), 0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        check("op1_exec_rdy0",  32'(rdy0),    0);
        check("op1_exec_valid", 32'(o_valid), 0);
        tick();
        check("op1_valid", 32'(o_valid), 1);
        check("op1_o",     32'(o),       32'h F2);
        check("op1_id",    32'(o_id),    0);
        tick();

        // ties alternate; port 0 was last served so port 1 goes first
        v0 = 1'b1; i0 = 8'h0F; n0 = 4'd2; ar0 = 1'b0; lr0 = 1'b1; rot0 = 1'b0;
        v1 = 1'b1; i1 = 8'h81; n1 = 4'd1; ar1 = 1'b0; lr1 = 1'b1; rot1 = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("tie_rdy1", 32'(rdy1), (k % 2 == 0) ? 1 : 0);
            check("tie_rdy0", 32'(rdy0), (k % 2 == 0) ? 0 : 1);
            tick();
            check("tie_exec_rdy", 32'({rdy1, rdy0}), 0);
            tick();
            check("tie_valid", 32'(o_valid), 1);
            check("tie_o",     32'(o),       (k % 2 == 0) ? 32'h03 : 32'h3C);
            check("tie_id",    32'(o_id),    (k % 2 == 0) ? 1 : 0);
            tick();
        end

        // backpressure: port 0 shl 0xFF by 12 -> 0x00, port 1 waits
        v1 = 1'b0;
        i0 = 8'hFF; n0 = 4'd12; ar0 = 1'b0; lr0 = 1'b1; rot0 = 1'b0;
        o_ready = 1'b0;
        #1;
        check("bp_rdy0", 32'(rdy0), 1);
        tick();
        v0 = 1'b0;
        v1 = 1'b1; i1 = 8'h01; n1 = 4'd9; ar1 = 1'b0; lr1 = 1'b0; rot1 = 1'b1;
        #1;
        check("bp_exec_rdy1", 32'(rdy1), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(o_valid), 1);
            check("bp_o",     32'(o),       0);
            check("bp_id",    32'(o_id),    0);
            check("bp_rdy1",  32'(rdy1),    0);
            tick();
        end
        o_ready = 1'b1;
        #1;
        check("bp_hs_rdy1", 32'(rdy1), 0);
        tick();
        check("bp_idle_rdy1",  32'(rdy1),    1);
        check("bp_idle_valid", 32'(o_valid), 0);
        tick();
        v1 = 1'b0;
        tick();
        check("ror_valid", 32'(o_valid), 1);
        check("ror_o",     32'(o),       32'h80);
        check("ror_id",    32'(o_id),    1);
        tick();

        // arithmetic right 0x80 by 15 -> 0xFF, then reset while stalled in DONE
        v0 = 1'b1; i0 = 8'h80; n0 = 4'd15; ar0 = 1'b1; lr0 = 1'b0; rot0 = 1'b0;
        o_ready = 1'b0;
        #1;
        check("asr_rdy0", 32'(rdy0), 1);
        tick();
        v0 = 1'b0;
        tick();
        check("asr_valid", 32'(o_valid), 1);
        check("asr_o",     32'(o),       32'hFF);
        tick();
        check("asr_hold_valid", 32'(o_valid), 1);
        nrst = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_o",     32'(o),       0);
        tick();
        check("midrst_hold_valid", 32'(o_valid), 0);

        // fresh op after reset: 0x96 lsr 1 = 0x4B
        nrst = 1'b1; o_ready = 1'b1;
        v0 = 1'b1; i0 = 8'h96; n0 = 4'd1; ar0 = 1'b0; lr0 = 1'b0; rot0 = 1'b0;
        #1;
        check("post_rdy0", 32'(rdy0), 1);
        tick();
        v0 = 1'b0;
        tick();
        check("post_valid", 32'(o_valid), 1);
        check("post_o",     32'(o),       32'h4B);
        check("post_id",    32'(o_id),    0);
        tick();
        check("post_idle_valid", 32'(o_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
